// File: rtl/modulator_select_scheduler.sv
// modulator_select_scheduler
// Owns the signal / modulation selector codes for the modulator display path.
// CPU writes are parked in pending registers and only committed on a
// waveform phase-wrap strobe, so the visible selection never changes in the
// middle of a waveform period. An auto-scan mode can step one selector
// through its valid codes after a programmable number of wraps.
//
// Register map (wr_addr / rd_addr):
//   0 SIG   wr: pending signal code      rd: committed signal_selector
//   1 MOD   wr: pending modulation code  rd: committed modulation_selector
//   2 CTRL  bit0 auto_scan, bit1 scan_target (0 = modulation, 1 = signal)
//           rd also returns bit2 busy, bit3 err (sticky, cleared by CTRL write)
//   3 DWELL wraps per scan step (0 behaves as 1), upper bits ignored
//
// Strobes: wr_en and wave_wrap are single-cycle qualifiers sampled on the
// rising clock edge; there is no back-pressure, every strobe is consumed in
// the cycle it is presented. When both arrive together the wrap acts on the
// state before the write, and the write lands afterwards.
module modulator_select_scheduler #(
    parameter int NUM_SIG = 4,
    parameter int NUM_MOD = 5,
    parameter int DWELL_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [1:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        wave_wrap,
    output logic [7:0]  signal_selector,
    output logic [3:0]  modulation_selector,
    output logic        sel_update,
    output logic        busy
);

    localparam logic [1:0] ADDR_SIG   = 2'd0;
    localparam logic [1:0] ADDR_MOD   = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;
    localparam logic [1:0] ADDR_DWELL = 2'd3;

    localparam logic [7:0] SIG_LIMIT = 8'(NUM_SIG);
    localparam logic [3:0] MOD_LIMIT = 4'(NUM_MOD);
    localparam logic [7:0] SIG_LAST  = 8'(NUM_SIG - 1);
    localparam logic [3:0] MOD_LAST  = 4'(NUM_MOD - 1);

    // IDLE: nothing pending, scan off. PEND: at least one manual write waits
    // for a wrap. SCAN: auto-scan on and nothing pending. PEND wins over SCAN.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t state_q;
    state_t state_n;

    // Architectural registers
    logic [7:0]         sig_q,       sig_n;
    logic [3:0]         mod_q,       mod_n;
    logic [7:0]         pend_sig_q,  pend_sig_n;
    logic [3:0]         pend_mod_q,  pend_mod_n;
    logic               has_sig_q,   has_sig_n;
    logic               has_mod_q,   has_mod_n;
    logic               auto_scan_q, auto_scan_n;
    logic               target_q,    target_n;
    logic               err_q,       err_n;
    logic [DWELL_W-1:0] dwell_q,     dwell_n;
    logic [DWELL_W-1:0] cnt_q,       cnt_n;
    logic               upd_q,       upd_n;
    logic [31:0]        rd_q,        rd_n;

    // Decoded write qualifiers
    logic sig_ok;
    logic mod_ok;
    logic wr_sig;
    logic wr_mod;
    logic wr_ctrl;
    logic wr_dwell;
    logic manual_wr;
    logic auto_after;

    // FSM decode outputs
    logic do_commit;
    logic do_count;

    // Scan counter helpers
    logic [DWELL_W-1:0] dwell_eff;
    logic [DWELL_W:0]   cnt_inc;

    // Write decode: a code is legal only if it is in range and no bits above
    // its field are set.
    always_comb begin
        sig_ok     = (wr_data[31:8] == 24'd0) && (wr_data[7:0] < SIG_LIMIT);
        mod_ok     = (wr_data[31:4] == 28'd0) && (wr_data[3:0] < MOD_LIMIT);
        wr_sig     = wr_en && (wr_addr == ADDR_SIG);
        wr_mod     = wr_en && (wr_addr == ADDR_MOD);
        wr_ctrl    = wr_en && (wr_addr == ADDR_CTRL);
        wr_dwell   = wr_en && (wr_addr == ADDR_DWELL);
        manual_wr  = (wr_sig && sig_ok) || (wr_mod && mod_ok);
        auto_after = wr_ctrl ? wr_data[0] : auto_scan_q;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // FSM next state and wrap actions; a wrap acts on the pre-write state
    always_comb begin
        state_n   = state_q;
        do_commit = 1'b0;
        do_count  = 1'b0;
        case (state_q)
            ST_PEND: begin
                do_commit = wave_wrap;
                if (!wave_wrap || manual_wr) begin
                    state_n = ST_PEND;
                end else if (auto_after) begin
                    state_n = ST_SCAN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SCAN, ST_IDLE: begin
                do_count = wave_wrap && (state_q == ST_SCAN);
                if (manual_wr) begin
                    state_n = ST_PEND;
                end else if (auto_after) begin
                    state_n = ST_SCAN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: wrap effects first, then the register write
    always_comb begin
        sig_n       = sig_q;
        mod_n       = mod_q;
        pend_sig_n  = pend_sig_q;
        pend_mod_n  = pend_mod_q;
        has_sig_n   = has_sig_q;
        has_mod_n   = has_mod_q;
        auto_scan_n = auto_scan_q;
        target_n    = target_q;
        err_n       = err_q;
        dwell_n     = dwell_q;
        cnt_n       = cnt_q;
        dwell_eff   = (dwell_q == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell_q;
        cnt_inc     = {1'b0, cnt_q} + {{DWELL_W{1'b0}}, 1'b1};

        if (do_commit) begin
            if (has_sig_q) begin
                sig_n = pend_sig_q;
            end
            if (has_mod_q) begin
                mod_n = pend_mod_q;
            end
            has_sig_n = 1'b0;
            has_mod_n = 1'b0;
            cnt_n     = '0;
        end

        if (do_count) begin
            // >= so that a DWELL lowered below the running count steps on the
            // very next wrap instead of waiting for the counter to wrap around
            if (cnt_inc >= {1'b0, dwell_eff}) begin
                cnt_n = '0;
                if (target_q) begin
                    sig_n = (sig_q == SIG_LAST) ? 8'd0 : sig_q + 8'd1;
                end else begin
                    mod_n = (mod_q == MOD_LAST) ? 4'd0 : mod_q + 4'd1;
                end
            end else begin
                cnt_n = cnt_inc[DWELL_W-1:0];
            end
        end

        if (wr_sig) begin
            if (sig_ok) begin
                pend_sig_n = wr_data[7:0];
                has_sig_n  = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end

        if (wr_mod) begin
            if (mod_ok) begin
                pend_mod_n = wr_data[3:0];
                has_mod_n  = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end

        if (wr_ctrl) begin
            auto_scan_n = wr_data[0];
            target_n    = wr_data[1];
            err_n       = 1'b0;
            if (!wr_data[0]) begin
                cnt_n = '0;
            end
        end

        if (wr_dwell) begin
            dwell_n = wr_data[DWELL_W-1:0];
        end
    end

    // sel_update flags any selector change made on this edge
    always_comb begin
        upd_n = (sig_n != sig_q) || (mod_n != mod_q);
    end

    // Read mux over the current register state; registered below
    always_comb begin
        rd_n = 32'd0;
        case (rd_addr)
            ADDR_SIG:   rd_n = {24'd0, sig_q};
            ADDR_MOD:   rd_n = {28'd0, mod_q};
            ADDR_CTRL:  rd_n = {28'd0, err_q, (has_sig_q | has_mod_q),
                                target_q, auto_scan_q};
            ADDR_DWELL: rd_n = 32'(dwell_q);
            default:    rd_n = 32'd0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q       <= 8'd0;
            mod_q       <= 4'd0;
            pend_sig_q  <= 8'd0;
            pend_mod_q  <= 4'd0;
            has_sig_q   <= 1'b0;
            has_mod_q   <= 1'b0;
            auto_scan_q <= 1'b0;
            target_q    <= 1'b0;
            err_q       <= 1'b0;
            dwell_q     <= {{(DWELL_W-1){1'b0}}, 1'b1};
            cnt_q       <= '0;
            upd_q       <= 1'b0;
            rd_q        <= 32'd0;
        end else begin
            sig_q       <= sig_n;
            mod_q       <= mod_n;
            pend_sig_q  <= pend_sig_n;
            pend_mod_q  <= pend_mod_n;
            has_sig_q   <= has_sig_n;
            has_mod_q   <= has_mod_n;
            auto_scan_q <= auto_scan_n;
            target_q    <= target_n;
            err_q       <= err_n;
            dwell_q     <= dwell_n;
            cnt_q       <= cnt_n;
            upd_q       <= upd_n;
            rd_q        <= rd_n;
        end
    end

    // Output drive
    always_comb begin
        signal_selector     = sig_q;
        modulation_selector = mod_q;
        sel_update          = upd_q;
        busy                = has_sig_q | has_mod_q;
        rd_data             = rd_q;
    end

endmodule

// File: tb/tb_modulator_select_scheduler.sv
// Testbench for modulator_select_scheduler: a fixed vector table, hand-written
// scan / reset sequences and randomized traffic against a behavioural model.
module tb_modulator_select_scheduler;

  localparam int NUM_SIG = 4;
  localparam int NUM_MOD = 5;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [1:0]  rd_addr = 2'd0;
  logic        wave_wrap = 1'b0;
  logic [31:0] rd_data;
  logic [7:0]  signal_selector;
  logic [3:0]  modulation_selector;
  logic        sel_update;
  logic        busy;

  always #5 clk = ~clk;

  modulator_select_scheduler dut (
    .clk                 (clk),
    .reset               (reset),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .wave_wrap           (wave_wrap),
    .signal_selector     (signal_selector),
    .modulation_selector (modulation_selector),
    .sel_update          (sel_update),
    .busy                (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: present one cycle of inputs, sample #1 after the edge
  task automatic apply(input logic we, input logic [1:0] a, input logic [31:0] d,
                       input logic [1:0] ra, input logic wr);
    wr_en     = we;
    wr_addr   = a;
    wr_data   = d;
    rd_addr   = ra;
    wave_wrap = wr;
    @(posedge clk);
    #1;
    wr_en     = 1'b0;
    wave_wrap = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_sig, m_mod, m_pend_sig, m_pend_mod, m_auto, m_tgt, m_err, m_dwell, m_cnt;

  task automatic model_reset();
    m_sig = 0; m_mod = 0; m_pend_sig = -1; m_pend_mod = -1;
    m_auto = 0; m_tgt = 0; m_err = 0; m_dwell = 1; m_cnt = 0;
  endtask

  function automatic int m_busy();
    return (m_pend_sig >= 0 || m_pend_mod >= 0) ? 1 : 0;
  endfunction

  function automatic int m_read(input int a);
    case (a)
      0: return m_sig;
      1: return m_mod;
      2: return m_auto + 2 * m_tgt + 4 * m_busy() + 8 * m_err;
      default: return m_dwell;
    endcase
  endfunction

  task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d,
                            input logic wr, output int upd);
    int old_sig = m_sig;
    int old_mod = m_mod;
    if (wr) begin
      if (m_busy() == 1) begin
        if (m_pend_sig >= 0) m_sig = m_pend_sig;
        if (m_pend_mod >= 0) m_mod = m_pend_mod;
        m_pend_sig = -1;
        m_pend_mod = -1;
        m_cnt = 0;
      end else if (m_auto == 1) begin
        m_cnt++;
        if (m_cnt >= ((m_dwell == 0) ? 1 : m_dwell)) begin
          if (m_tgt == 1) m_sig = (m_sig + 1) % NUM_SIG;
          else            m_mod = (m_mod + 1) % NUM_MOD;
          m_cnt = 0;
        end
      end
    end
    if (we) begin
      case (a)
        2'd0: if (d < 32'(NUM_SIG)) m_pend_sig = int'(d); else m_err = 1;
        2'd1: if (d < 32'(NUM_MOD)) m_pend_mod = int'(d); else m_err = 1;
        2'd2: begin
          m_auto = int'(d[0]);
          m_tgt  = int'(d[1]);
          m_err  = 0;
          if (m_auto == 0) m_cnt = 0;
        end
        default: m_dwell = int'(d & 32'h0000_FFFF);
      endcase
    end
    upd = (m_sig != old_sig || m_mod != old_mod) ? 1 : 0;
  endtask

  // one model-checked cycle
  task automatic mcycle(input logic we, input logic [1:0] a, input logic [31:0] d,
                        input logic [1:0] ra, input logic wr);
    int exp_rd;
    int exp_upd;
    exp_rd = m_read(int'(ra));
    model_step(we, a, d, wr, exp_upd);
    apply(we, a, d, ra, wr);
    chk("m_sig",  32'(signal_selector),     32'(m_sig));
    chk("m_mod",  32'(modulation_selector), 32'(m_mod));
    chk("m_upd",  32'(sel_update),          32'(exp_upd));
    chk("m_busy", 32'(busy),                32'(m_busy()));
    chk("m_rd",   rd_data,                  32'(exp_rd));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [1:0]  raddr;
    logic        wrap;
    logic [7:0]  e_sig;
    logic [3:0]  e_mod;
    logic        e_upd;
    logic        e_busy;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic we, input logic [1:0] a, input logic [31:0] d,
                              input logic [1:0] ra, input logic wr, input logic [7:0] s,
                              input logic [3:0] m, input logic u, input logic b,
                              input logic [31:0] r);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.raddr = ra; v.wrap = wr;
    v.e_sig = s; v.e_mod = m; v.e_upd = u; v.e_busy = b; v.e_rd = r;
    return v;
  endfunction

  int pulses;

  initial begin
    //           we  a     data          ra    wrap sig  mod  upd  busy rd
    tbl[0]  = mk(0, 2'd0, 32'd0,        2'd0, 0, 8'd0, 4'd0, 0, 0, 32'd0);
    tbl[1]  = mk(0, 2'd0, 32'd0,        2'd1, 0, 8'd0, 4'd0, 0, 0, 32'd0);
    tbl[2]  = mk(0, 2'd0, 32'd0,        2'd2, 0, 8'd0, 4'd0, 0, 0, 32'd0);
    tbl[3]  = mk(0, 2'd0, 32'd0,        2'd3, 0, 8'd0, 4'd0, 0, 0, 32'd1);
    tbl[4]  = mk(1, 2'd1, 32'd3,        2'd0, 0, 8'd0, 4'd0, 0, 1, 32'd0);
    tbl[5]  = mk(0, 2'd0, 32'd0,        2'd1, 0, 8'd0, 4'd0, 0, 1, 32'd0);
    tbl[6]  = mk(0, 2'd0, 32'd0,        2'd2, 0, 8'd0, 4'd0, 0, 1, 32'd4);
    tbl[7]  = mk(0, 2'd0, 32'd0,        2'd1, 1, 8'd0, 4'd3, 1, 0, 32'd0);
    tbl[8]  = mk(0, 2'd0, 32'd0,        2'd1, 0, 8'd0, 4'd3, 0, 0, 32'd3);
    tbl[9]  = mk(1, 2'd0, 32'd5,        2'd2, 0, 8'd0, 4'd3, 0, 0, 32'd0);
    tbl[10] = mk(0, 2'd0, 32'd0,        2'd2, 0, 8'd0, 4'd3, 0, 0, 32'd8);
    tbl[11] = mk(1, 2'd2, 32'd0,        2'd2, 0, 8'd0, 4'd3, 0, 0, 32'd8);
    tbl[12] = mk(0, 2'd0, 32'd0,        2'd2, 0, 8'd0, 4'd3, 0, 0, 32'd0);
    tbl[13] = mk(1, 2'd0, 32'd2,        2'd0, 1, 8'd0, 4'd3, 0, 1, 32'd0);
    tbl[14] = mk(0, 2'd0, 32'd0,        2'd0, 1, 8'd2, 4'd3, 1, 0, 32'd0);
    tbl[15] = mk(0, 2'd0, 32'd0,        2'd0, 0, 8'd2, 4'd3, 0, 0, 32'd2);
    tbl[16] = mk(1, 2'd1, 32'h10,       2'd3, 0, 8'd2, 4'd3, 0, 0, 32'd1);
    tbl[17] = mk(0, 2'd0, 32'd0,        2'd2, 0, 8'd2, 4'd3, 0, 0, 32'd8);
    tbl[18] = mk(1, 2'd2, 32'd0,        2'd2, 0, 8'd2, 4'd3, 0, 0, 32'd8);
    tbl[19] = mk(0, 2'd0, 32'd0,        2'd2, 0, 8'd2, 4'd3, 0, 0, 32'd0);

    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_sig",  32'(signal_selector),     32'd0);
    chk("rst_mod",  32'(modulation_selector), 32'd0);
    chk("rst_upd",  32'(sel_update),          32'd0);
    chk("rst_busy", 32'(busy),                32'd0);
    chk("rst_rd",   rd_data,                  32'd0);
    reset = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].raddr, tbl[i].wrap);
      chk($sformatf("tbl%0d_sig", i),  32'(signal_selector),     32'(tbl[i].e_sig));
      chk($sformatf("tbl%0d_mod", i),  32'(modulation_selector), 32'(tbl[i].e_mod));
      chk($sformatf("tbl%0d_upd", i),  32'(sel_update),          32'(tbl[i].e_upd));
      chk($sformatf("tbl%0d_busy", i), 32'(busy),                32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_rd", i),   rd_data,                  tbl[i].e_rd);
    end

    // auto-scan of modulation, DWELL=2, ten wraps
    do_reset();
    mcycle(1, 2'd3, 32'd2, 2'd0, 0);
    mcycle(1, 2'd2, 32'd1, 2'd0, 0);
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      mcycle(0, 2'd0, 32'd0, 2'd1, 1);
      if (sel_update) pulses++;
      chk($sformatf("scan_wrap%0d", k), 32'(modulation_selector), 32'((k / 2) % NUM_MOD));
      mcycle(0, 2'd0, 32'd0, 2'd1, 0);
      if (sel_update) pulses++;
    end
    chk("scan_pulses", 32'(pulses), 32'd5);

    // reset asserted mid-scan with a modulation write pending
    do_reset();
    mcycle(1, 2'd0, 32'd1, 2'd0, 0);
    mcycle(0, 2'd0, 32'd0, 2'd0, 1);
    mcycle(1, 2'd3, 32'd3, 2'd0, 0);
    mcycle(1, 2'd2, 32'd1, 2'd0, 0);
    mcycle(0, 2'd0, 32'd0, 2'd0, 1);
    mcycle(0, 2'd0, 32'd0, 2'd0, 1);
    mcycle(1, 2'd1, 32'd2, 2'd2, 0);
    chk("pend_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #2;
    chk("arst_sig",  32'(signal_selector),     32'd0);
    chk("arst_mod",  32'(modulation_selector), 32'd0);
    chk("arst_busy", 32'(busy),                32'd0);
    chk("arst_rd",   rd_data,                  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    mcycle(0, 2'd0, 32'd0, 2'd2, 0);
    chk("arst_ctrl", rd_data, 32'd0);
    mcycle(0, 2'd0, 32'd0, 2'd3, 0);
    chk("arst_dwell", rd_data, 32'd1);
    mcycle(0, 2'd0, 32'd0, 2'd0, 1);
    chk("arst_nocommit", 32'(modulation_selector), 32'd0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic        we;
      logic [1:0]  a;
      logic [31:0] d;
      int          r;
      we = ($urandom_range(0, 99) < 35);
      a  = 2'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 9));
      if (a == 2'd3) begin
        d = 32'($urandom_range(0, 3));
        if (r == 9) d = d | 32'h0001_0000;
      end else if (a == 2'd2) begin
        d = 32'($urandom_range(0, 3));
        if (r == 9) d = d | 32'h0000_0100;
      end else if (r < 7) begin
        d = 32'($urandom_range(0, 6));
      end else if (r < 9) begin
        d = 32'($urandom_range(0, 3)) | (32'd1 << $urandom_range(4, 31));
      end else begin
        d = $urandom;
      end
      mcycle(we, a, d, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/modulator_select_scheduler.md
# modulator_select_scheduler

Register-mapped controller that owns the signal and modulation selector codes driving the modulator display path. CPU writes are held pending and committed only on a waveform phase-wrap strobe, so the displayed selection never switches mid-period. An optional auto-scan mode steps the modulation or signal selector through its valid codes after a programmable number of wraps. The block sits between the Nios avalon slave decode and the modulator signal selector.

## Interface
- NUM_SIG, 4, number of valid signal codes (0..NUM_SIG-1)
- NUM_MOD, 5, number of valid modulation codes (0..NUM_MOD-1)
- DWELL_W, 16, width of dwell register and wrap counter
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  single-cycle write strobe
- wr_addr  in  2  write register address
- wr_data  in  32  write data
- rd_addr  in  2  read register address, sampled every cycle
- rd_data  out  32  registered read data
- wave_wrap  in  1  one-cycle pulse at waveform phase wrap (commit boundary)
- signal_selector  out  8  committed signal code
- modulation_selector  out  4  committed modulation code
- sel_update  out  1  one-cycle pulse on the cycle after any selector changes
- busy  out  1  a manual write is pending commit

## Operation
- Register map: 0 SIG (wr: pending signal code; rd: committed signal_selector), 1 MOD (wr: pending modulation code; rd: committed modulation_selector), 2 CTRL (bit0 auto_scan, bit1 scan_target: 0 = modulation, 1 = signal; rd adds bit2 busy, bit3 err), 3 DWELL (wrap count per scan step, DWELL_W bits, upper bits ignored).
- Write to SIG with wr_data[7:0] >= NUM_SIG, or to MOD with wr_data[3:0] >= NUM_MOD, or nonzero bits above those fields: write ignored, sticky err set. err is cleared by any CTRL write.
- Valid SIG/MOD write: value latched into that selector's pending register, its pending flag set; a second write before commit overwrites the pending value.
- States: IDLE (no pending, scan off), PEND (≥1 pending flag), SCAN (auto_scan=1, no pending). PEND has priority over SCAN.
- On wave_wrap in PEND: all pending values commit to outputs, flags clear, wrap counter clears; go to SCAN if auto_scan else IDLE.
- In SCAN, each wave_wrap increments the wrap counter; when the counter reaches max(DWELL,1), the scan_target selector advances by 1 modulo NUM_MOD or NUM_SIG (wrap to 0), counter clears.
- Manual write while in SCAN: enters PEND; counter clears on commit.
- Clearing auto_scan: counter clears, selectors hold.
- Changing DWELL while scanning: counter is not cleared; if counter ≥ new DWELL, the step occurs on the next wrap.
- Write and wave_wrap in the same cycle: the wrap acts on state before the write; the written value becomes pending for the next wrap.

## Timing
- Reset values: signal_selector 0, modulation_selector 0, sel_update 0, busy 0, rd_data 0, CTRL 0, DWELL 1, err 0, pending flags and counter 0.
- Commit: selector outputs change on the clk edge that samples wave_wrap=1; sel_update is high in the following cycle only.
- busy rises the cycle after the accepted write, falls on the commit edge.
- rd_data: one-cycle latency from rd_addr; reflects register state as of the previous edge.
- wave_wrap held high for multiple cycles counts once per high cycle. Spec requires single-cycle pulses.
- Reset asserted mid-pending: pending discarded, all outputs return to reset values asynchronously.

## Test plan
- Reset then read all four addresses -> 0, 0, 0, 1; selectors 0, sel_update 0.
- Write MOD=3, wait 10 cycles with no wrap -> modulation_selector stays 0, busy=1; pulse wave_wrap -> modulation_selector=3 on that edge, sel_update high one cycle, busy 0.
- Write SIG=5 -> ignored, CTRL read shows err=1, signal_selector 0; write CTRL=0 -> err=0.
- CTRL=1, DWELL=2, issue 10 wraps -> modulation_selector sequence 0,1,2,3,4,0 (one step per 2 wraps), 5 sel_update pulses.
- Write SIG=2 in the same cycle as a wrap -> no change that edge; next wrap commits signal_selector=2.
- Scanning with DWELL=3, assert reset after 2 wraps while MOD write pending -> outputs 0, busy 0, CTRL 0, DWELL 1.
